// File: rtl/inference_seq_pkg.sv
// Shared types and helpers for inference_sequencer.
//   seq_state_e : controller state encoding (IDLE=0 so reset clears to IDLE)
//   SETTLE_W    : settle-counter width; NET_LATENCY must fit (0..255)
//   MAX_CLASSES : widest class vector is_onehot() accepts
//   is_onehot() : 1 when exactly one bit of the argument is set
package inference_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    SETTLE = 3'd2,
    FIRE   = 3'd3,
    WAIT   = 3'd4,
    HOLD   = 3'd5
  } seq_state_e;

  localparam int unsigned SETTLE_W    = 8;
  localparam int unsigned MAX_CLASSES = 64;

  // Callers zero-extend their class vector to MAX_CLASSES bits; zero
  // padding does not change the one-hot property.
  function automatic bit is_onehot(input logic [MAX_CLASSES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/inference_sequencer.sv
// inference_sequencer: sequences one sample at a time through the gate
// network and the output accumulator/classifier.
//   clk_i, reset_i          clock, synchronous active-high reset
//   sample_valid_i/ready_o  input sample stream, data on sample_i
//   net_data_o              registered sample held on the network input
//   cls_valid_o/cls_reset_o one-cycle pulses to the classifier
//   cls_valid_i/cls_class_i classifier result
//   flush_i                 request a classifier flush (sampled in IDLE only)
//   res_valid_o/res_ready_i result stream, res_class_o / res_err_o
//   done_cnt_o              completed inferences (wraps)
//   busy_o                  controller not idle
// Optional: define INFER_SEQ_TIMEOUT_EN to add a WAIT-state watchdog of
// TIMEOUT_CYCLES cycles that returns an error result and flushes the
// classifier.
module inference_sequencer
  import inference_seq_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = 784,
  parameter int unsigned NUM_CLASSES    = 10,
  parameter int unsigned NET_LATENCY    = 4,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   sample_valid_i,
  output logic                   sample_ready_o,
  input  logic [IN_WIDTH-1:0]    sample_i,
  output logic [IN_WIDTH-1:0]    net_data_o,
  output logic                   cls_valid_o,
  output logic                   cls_reset_o,
  input  logic                   cls_valid_i,
  input  logic [NUM_CLASSES-1:0] cls_class_i,
  input  logic                   flush_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [NUM_CLASSES-1:0] res_class_o,
  output logic                   res_err_o,
  output logic [CNT_WIDTH-1:0]   done_cnt_o,
  output logic                   busy_o
);

  seq_state_e             state_q, state_d;
  logic [SETTLE_W-1:0]    settle_q, settle_d;
  logic [IN_WIDTH-1:0]    net_q, net_d;
  logic                   cls_valid_q, cls_valid_d;
  logic                   cls_reset_q, cls_reset_d;
  logic                   res_valid_q, res_valid_d;
  logic [NUM_CLASSES-1:0] res_class_q, res_class_d;
  logic                   res_err_q, res_err_d;
  logic [CNT_WIDTH-1:0]   done_q, done_d;

`ifdef INFER_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Reset also masks ready so nothing looks accepted while held in reset.
  assign sample_ready_o = (state_q == IDLE) && !flush_i && !reset_i;
  assign busy_o         = (state_q != IDLE);
  assign net_data_o     = net_q;
  assign cls_valid_o    = cls_valid_q;
  assign cls_reset_o    = cls_reset_q;
  assign res_valid_o    = res_valid_q;
  assign res_class_o    = res_class_q;
  assign res_err_o      = res_err_q;
  assign done_cnt_o     = done_q;

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    net_d       = net_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;
    done_d      = done_q;
    cls_reset_d = 1'b0;
`ifdef INFER_SEQ_TIMEOUT_EN
    // Zero outside WAIT, so the count restarts on every WAIT entry.
    wd_d = (state_q == WAIT) ? wd_q + 1'b1 : '0;
`endif
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = FLUSH;
        end else if (sample_valid_i) begin
          net_d    = sample_i;
          settle_d = SETTLE_W'(NET_LATENCY);
          state_d  = (NET_LATENCY == 0) ? FIRE : SETTLE;
        end
      end
      FLUSH: state_d = IDLE;
      SETTLE: begin
        // Loaded with NET_LATENCY; FIRE follows the cycle it reads 1, giving
        // exactly NET_LATENCY SETTLE cycles.
        if (settle_q == SETTLE_W'(1)) state_d = FIRE;
        else                          settle_d = settle_q - 1'b1;
      end
      FIRE: state_d = WAIT;
      WAIT: begin
        if (cls_valid_i) begin
          res_class_d = cls_class_i;
          res_err_d   = !is_onehot(MAX_CLASSES'(cls_class_i));
          state_d     = HOLD;
        end
`ifdef INFER_SEQ_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          res_class_d = '0;
          res_err_d   = 1'b1;
          cls_reset_d = 1'b1;
          state_d     = HOLD;
        end
`endif
      end
      HOLD: begin
        if (res_ready_i) begin
          done_d  = done_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Pulses and result-valid are registered from the next state so they
    // line up exactly with the state they belong to.
    cls_valid_d = (state_d == FIRE);
    cls_reset_d = cls_reset_d | (state_d == FLUSH);
    res_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      net_q       <= '0;
      cls_valid_q <= 1'b0;
      cls_reset_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
      done_q      <= '0;
`ifdef INFER_SEQ_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      net_q       <= net_d;
      cls_valid_q <= cls_valid_d;
      cls_reset_q <= cls_reset_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
      done_q      <= done_d;
`ifdef INFER_SEQ_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Self-checking bench for inference_sequencer. Instance "dut" uses
// NET_LATENCY=4 (TIMEOUT_CYCLES=8), instance "dut0" uses NET_LATENCY=0.
// The classifier is modelled directly by the bench. Timeout checks run
// when INFER_SEQ_TIMEOUT_EN is defined.
module tb_inference_sequencer;
  localparam int unsigned IW  = 784;
  localparam int unsigned NC  = 10;
  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned TO  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sv, sr, cvo, cro, cvi, fl, rv, rr, re, busy;
  logic [IW-1:0] smp, nd;
  logic [NC-1:0] cci, rc;
  logic [CW-1:0] dc;

  logic          sv0, sr0, cvo0, cro0, cvi0, rv0, rr0, re0, busy0;
  logic [IW-1:0] smp0, nd0;
  logic [NC-1:0] cci0, rc0;
  logic [CW-1:0] dc0;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  int unsigned   exp_cnt = 0;
  logic [IW-1:0] exp_net = '0;

  always #5 clk = ~clk;

  inference_sequencer #(.IN_WIDTH(IW), .NUM_CLASSES(NC), .NET_LATENCY(LAT),
                        .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_i(rst), .sample_valid_i(sv), .sample_ready_o(sr),
    .sample_i(smp), .net_data_o(nd), .cls_valid_o(cvo), .cls_reset_o(cro),
    .cls_valid_i(cvi), .cls_class_i(cci), .flush_i(fl), .res_valid_o(rv),
    .res_ready_i(rr), .res_class_o(rc), .res_err_o(re), .done_cnt_o(dc),
    .busy_o(busy));

  inference_sequencer #(.IN_WIDTH(IW), .NUM_CLASSES(NC), .NET_LATENCY(0),
                        .CNT_WIDTH(CW)) dut0 (
    .clk_i(clk), .reset_i(rst), .sample_valid_i(sv0), .sample_ready_o(sr0),
    .sample_i(smp0), .net_data_o(nd0), .cls_valid_o(cvo0), .cls_reset_o(cro0),
    .cls_valid_i(cvi0), .cls_class_i(cci0), .flush_i(1'b0), .res_valid_o(rv0),
    .res_ready_i(rr0), .res_class_o(rc0), .res_err_o(re0), .done_cnt_o(dc0),
    .busy_o(busy0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] rand_sample();
    logic [799:0] t;
    for (int i = 0; i < 25; i++) t[i*32 +: 32] = $urandom;
    return t[IW-1:0];
  endfunction

  function automatic logic [NC-1:0] rand_class();
    logic [NC-1:0] c;
    if ($urandom_range(0, 3) == 0) c = NC'($urandom);
    else c = NC'(1) << $urandom_range(0, NC - 1);
    return c;
  endfunction

  // One full transaction against the reference rules: cls_valid_o exactly
  // LAT+1 cycles after accept, error = not exactly one bit set, one count
  // per result handshake.
  task automatic inference(input logic [NC-1:0] cls, input int unsigned hold,
                           input int unsigned dly);
    logic exp_err;
    exp_err = ($countones(cls) != 1);
    smp = rand_sample(); sv = 1'b1; #1;
    vectors++; if (sr !== 1'b1) begin miscompares++; $display("FAIL accept_ready got %b want 1", sr); end
    tick();
    sv = 1'b0; exp_net = smp; smp = rand_sample();
    for (int k = 1; k <= LAT + 1; k++) begin
      vectors++; if (cvo !== (k == LAT + 1)) begin miscompares++; $display("FAIL cls_valid_timing k=%0d got %b want %b", k, cvo, (k == LAT + 1)); end
      vectors++; if (nd !== exp_net) begin miscompares++; $display("FAIL net_data_hold k=%0d got %h want %h", k, nd, exp_net); end
      vectors++; if (busy !== 1'b1 || sr !== 1'b0) begin miscompares++; $display("FAIL busy_ready k=%0d got busy=%b ready=%b want 1/0", k, busy, sr); end
      if (k <= LAT) tick();
    end
    tick();
    for (int d = 0; d < dly; d++) begin
      vectors++; if (rv !== 1'b0 || cvo !== 1'b0) begin miscompares++; $display("FAIL wait_quiet got rv=%b cvo=%b want 0/0", rv, cvo); end
      tick();
    end
    cvi = 1'b1; cci = cls; tick();
    cvi = 1'b0; cci = NC'($urandom);
    vectors++; if (rv !== 1'b1 || rc !== cls || re !== exp_err) begin miscompares++; $display("FAIL result got rv=%b class=%b err=%b want 1/%b/%b", rv, rc, re, cls, exp_err); end
    for (int h = 0; h < hold; h++) begin
      tick();
      vectors++; if (rv !== 1'b1 || rc !== cls || re !== exp_err || sr !== 1'b0 || dc !== CW'(exp_cnt)) begin
        miscompares++; $display("FAIL backpressure h=%0d got rv=%b class=%b err=%b ready=%b cnt=%0d want 1/%b/%b/0/%0d", h, rv, rc, re, sr, dc, cls, exp_err, exp_cnt); end
    end
    rr = 1'b1; tick(); rr = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    vectors++; if (rv !== 1'b0 || dc !== CW'(exp_cnt) || busy !== 1'b0 || sr !== 1'b1 || nd !== exp_net) begin
      miscompares++; $display("FAIL handshake got rv=%b cnt=%0d busy=%b ready=%b want 0/%0d/0/1", rv, dc, busy, sr, exp_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    vectors++; if (nd !== '0 || cvo !== 0 || cro !== 0 || rv !== 0 || rc !== '0 || re !== 0 || dc !== '0 || busy !== 0 || sr !== 0) begin
      miscompares++; $display("FAIL reset_values got rv=%b cvo=%b cro=%b class=%b err=%b cnt=%0d busy=%b ready=%b want all 0", rv, cvo, cro, rc, re, dc, busy, sr); end
    rst = 1'b0; #1;
    vectors++; if (sr !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset got %b want 1", sr); end
  endtask

  task automatic test_basic();
    inference(10'b0000001000, 0, 0);
  endtask

  task automatic test_backpressure();
    inference(NC'(1) << $urandom_range(0, NC - 1), 20, $urandom_range(0, 4));
  endtask

  task automatic test_error();
    inference(10'b0000000000, $urandom_range(0, 2), $urandom_range(0, 2));
    inference(10'b0000000011, $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      inference(rand_class(), $urandom_range(0, 3), $urandom_range(0, 4));
  endtask

  task automatic test_flush();
    fl = 1'b1; sv = 1'b1; smp = rand_sample(); #1;
    vectors++; if (sr !== 1'b0) begin miscompares++; $display("FAIL flush_priority_ready got %b want 0", sr); end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (cro !== (k % 2 == 0)) begin miscompares++; $display("FAIL flush_pulse k=%0d got %b want %b", k, cro, (k % 2 == 0)); end
      vectors++; if (nd !== exp_net || cvo !== 1'b0) begin miscompares++; $display("FAIL flush_no_accept k=%0d got net=%h cvo=%b want %h/0", k, nd, cvo, exp_net); end
    end
    fl = 1'b0;
    inference(rand_class(), 0, 1);
  endtask

  task automatic test_reset_mid_wait();
    smp = rand_sample(); sv = 1'b1; tick(); sv = 1'b0;
    for (int k = 0; k < LAT + 1; k++) tick();
    vectors++; if (busy !== 1'b1 || rv !== 1'b0 || cvo !== 1'b0) begin miscompares++; $display("FAIL in_wait got busy=%b rv=%b cvo=%b want 1/0/0", busy, rv, cvo); end
    rst = 1'b1; #1;
    vectors++; if (sr !== 1'b0) begin miscompares++; $display("FAIL ready_in_reset got %b want 0", sr); end
    tick(); rst = 1'b0; exp_cnt = 0; exp_net = '0;
    vectors++; if (nd !== '0 || cvo !== 0 || cro !== 0 || rv !== 0 || rc !== '0 || re !== 0 || dc !== '0 || busy !== 0) begin
      miscompares++; $display("FAIL reset_mid_wait got net=%h rv=%b class=%b cnt=%0d busy=%b want all 0", nd, rv, rc, dc, busy); end
    cvi = 1'b1; cci = 10'b0000010000; tick(); cvi = 1'b0;
    vectors++; if (rv !== 1'b0 || busy !== 1'b0 || rc !== '0) begin miscompares++; $display("FAIL late_cls_valid got rv=%b busy=%b class=%b want 0/0/0", rv, busy, rc); end
  endtask

  task automatic test_zero_latency();
    logic [NC-1:0] cls;
    logic [IW-1:0] s;
    cls = NC'(1) << $urandom_range(0, NC - 1);
    s = rand_sample(); smp0 = s; sv0 = 1'b1; #1;
    vectors++; if (sr0 !== 1'b1) begin miscompares++; $display("FAIL lat0_ready got %b want 1", sr0); end
    tick(); sv0 = 1'b0;
    vectors++; if (cvo0 !== 1'b1 || nd0 !== s) begin miscompares++; $display("FAIL lat0_fire got cvo=%b net=%h want 1/%h", cvo0, nd0, s); end
    tick();
    vectors++; if (cvo0 !== 1'b0) begin miscompares++; $display("FAIL lat0_pulse_width got %b want 0", cvo0); end
    cvi0 = 1'b1; cci0 = cls; tick(); cvi0 = 1'b0;
    vectors++; if (rv0 !== 1'b1 || rc0 !== cls || re0 !== 1'b0) begin miscompares++; $display("FAIL lat0_result got rv=%b class=%b err=%b want 1/%b/0", rv0, rc0, re0, cls); end
    rr0 = 1'b1; tick(); rr0 = 1'b0;
    vectors++; if (rv0 !== 1'b0 || dc0 !== CW'(1) || busy0 !== 1'b0) begin miscompares++; $display("FAIL lat0_done got rv=%b cnt=%0d busy=%b want 0/1/0", rv0, dc0, busy0); end
  endtask

`ifdef INFER_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    smp = rand_sample(); sv = 1'b1; tick(); sv = 1'b0;
    for (int k = 0; k < LAT + 1; k++) tick();
    for (int w = 1; w <= TO; w++) begin
      vectors++; if (rv !== 1'b0 || cro !== 1'b0) begin miscompares++; $display("FAIL timeout_early w=%0d got rv=%b cro=%b want 0/0", w, rv, cro); end
      if (w < TO) tick();
    end
    tick();
    vectors++; if (rv !== 1'b1 || re !== 1'b1 || rc !== '0 || cro !== 1'b1) begin
      miscompares++; $display("FAIL timeout_result got rv=%b err=%b class=%b cro=%b want 1/1/0/1", rv, re, rc, cro); end
    tick();
    vectors++; if (cro !== 1'b0 || rv !== 1'b1) begin miscompares++; $display("FAIL timeout_pulse got cro=%b rv=%b want 0/1", cro, rv); end
    rr = 1'b1; tick(); rr = 1'b0; exp_cnt = exp_cnt + 1;
    vectors++; if (dc !== CW'(exp_cnt) || rv !== 1'b0) begin miscompares++; $display("FAIL timeout_done got cnt=%0d rv=%b want %0d/0", dc, rv, exp_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; sv = 0; smp = '0; cvi = 0; cci = '0; fl = 0; rr = 0;
    sv0 = 0; smp0 = '0; cvi0 = 0; cci0 = '0; rr0 = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_error();
    test_random();
    test_reset_mid_wait();
    test_zero_latency();
`ifdef INFER_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_basic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL time_limit reached got running want finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
- Controller in front of the logic-gate network and output_accumulator_classifier.
- Accepts one input sample at a time over a valid/ready stream and holds it stable on the network input.
- Waits the network's fixed settle latency, then pulses the classifier's input-valid, waits for its out-valid, and returns the class over a valid/ready result stream.
- Also sequences classifier flushes (moving-average clear) and counts completed inferences.

Parameters:
- IN_WIDTH, 784: sample width, bits.
- NUM_CLASSES, 10: classifier one-hot class width.
- NET_LATENCY, 4: cycles from a stable net input until the classifier may sample it; legal range 0..255.
- CNT_WIDTH, 16: width of the completed-inference counter.
- TIMEOUT_CYCLES, 1024: watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- sample_valid_i  in  1  input sample offered.
- sample_ready_o  out  1  sequencer accepts a sample this cycle.
- sample_i  in  IN_WIDTH  sample data.
- net_data_o  out  IN_WIDTH  registered sample driven to the network.
- cls_valid_o  out  1  one-cycle pulse to the classifier's inp_valid_i.
- cls_reset_o  out  1  one-cycle pulse to the classifier's reset_i (flush).
- cls_valid_i  in  1  classifier out_valid_o.
- cls_class_i  in  NUM_CLASSES  classifier class_out_o.
- flush_i  in  1  request to clear classifier moving-average state.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  result consumer ready.
- res_class_o  out  NUM_CLASSES  captured class.
- res_err_o  out  1  captured class was not one-hot (or timed out).
- done_cnt_o  out  CNT_WIDTH  completed-inference count.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE. All outputs 0, including net_data_o, res_class_o and done_cnt_o.
- Reset takes effect the cycle after reset_i is sampled high, from any state. It abandons any in-flight sample and result and asserts no classifier pulses.
- FSM states: IDLE, FLUSH, SETTLE, FIRE, WAIT, HOLD.
- IDLE:
  - sample_ready_o = 1 only when flush_i = 0.
  - flush_i = 1 has priority over a sample: go to FLUSH, with sample_ready_o = 0 that cycle.
  - On sample_valid_i and sample_ready_o: capture net_data_o <= sample_i, load the settle counter with NET_LATENCY, go to SETTLE. If NET_LATENCY = 0, go directly to FIRE.
- FLUSH: cls_reset_o = 1 for exactly one cycle, then IDLE. flush_i held high re-enters FLUSH every other cycle.
- SETTLE: decrement the counter; go to FIRE the cycle it reaches 1. Total sample-accept to cls_valid_o = NET_LATENCY + 1 cycles.
- FIRE: cls_valid_o = 1 for exactly one cycle, then WAIT. net_data_o stays stable from capture until the next accept.
- WAIT:
  - On cls_valid_i: capture res_class_o <= cls_class_i.
  - Set res_err_o = 1 if cls_class_i is not one-hot (zero bits set or more than one bit set).
  - Go to HOLD.
  - cls_valid_i in any state other than WAIT is ignored.
- HOLD:
  - res_valid_o = 1; res_class_o and res_err_o are held stable until res_ready_i.
  - On res_valid_o and res_ready_i: done_cnt_o increments, wrapping at 2^CNT_WIDTH. Go to IDLE.
  - res_ready_i = 1 on the first HOLD cycle gives a one-cycle handshake.
- Throughput: one outstanding sample. IDLE is always spent for at least one cycle between results. A new sample can be accepted no earlier than the cycle after the result handshake.
- flush_i outside IDLE is not latched. It must be held until sampled in IDLE.
- Registered outputs: net_data_o, cls_valid_o, cls_reset_o, res_*, done_cnt_o.
- Decoded from state: sample_ready_o and busy_o.

Optional Feature:
- Macro INFER_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts WAIT cycles.
  - If TIMEOUT_CYCLES cycles pass without cls_valid_i: go to HOLD with res_class_o = 0 and res_err_o = 1, and pulse cls_reset_o for one cycle on entry to HOLD.
  - The counter clears on WAIT entry.
- Undefined: WAIT waits indefinitely; no watchdog logic.

Decomposition:
- Package inference_seq_pkg:
  - state enum seq_state_e (IDLE, FLUSH, SETTLE, FIRE, WAIT, HOLD);
  - localparam for settle-counter width (8);
  - function is_onehot(logic [NUM_CLASSES-1:0]) returning bit.
- No sub-module; single FSM plus counters.
- Bench integration instantiates inference_sequencer with output_accumulator_classifier. The network is modelled as a NET_LATENCY-stage delay of net_data_o.

Test Plan:
- Basic, NET_LATENCY=4:
  - Stimulus: sample accepted at cycle t.
  - Response: cls_valid_o high only at t+5. Classifier returns 10'b0000001000, then res_ready_i=1. Expect res_class_o=10'b0000001000, res_err_o=0, done_cnt_o=1, sample_ready_o=1 next cycle.
- Backpressure: res_ready_i=0 for 20 cycles, then 1.
  - Response: res_valid_o stays 1 with stable class; sample_ready_o=0 throughout; exactly one count increment.
- Flush priority: flush_i=1 and sample_valid_i=1 in IDLE.
  - Response: sample not accepted; cls_reset_o pulses exactly 1 cycle; sample accepted the cycle after return to IDLE.
- Error: classifier returns 10'b0000000000 and, separately, 10'b0000000011.
  - Response: res_err_o=1 for both.
- Reset mid-WAIT, then NET_LATENCY=0 build:
  - Response after reset: all outputs 0, state IDLE, late cls_valid_i ignored.
  - NET_LATENCY=0 build: cls_valid_o at accept+1.
- INFER_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=8 and the classifier silent:
  - Response: res_valid_o=1, res_err_o=1, res_class_o=0 after 8 WAIT cycles; cls_reset_o pulses once.
